// File: rtl/simon_pkg.sv
// Shared types for the Simon sequencer: colour type, FSM state encoding and
// small elaboration-time helpers used for register sizing.
package simon_pkg;

  typedef logic [1:0] color_t;

  typedef enum logic [2:0] {
    IDLE,
    ADD,
    SHOW_ON,
    SHOW_OFF,
    WAIT_IN,
    ROUND,
    FAIL,
    WIN
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // $clog2 that never returns 0, so a 1-entry range still gets a 1-bit field
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/simon_timer.sv
// Loadable down-counter shared by playback and input-timeout phases.
// Holds at zero; o_done is high whenever the count is zero.
module simon_timer #(
  parameter int W = 3
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_count <= '0;
    else if (i_load)
      r_count <= i_load_val;
    else if (r_count != '0)
      r_count <= r_count - W'(1);
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/simon_seq_player.sv
// Simon game sequencer: grows a colour sequence each round, plays it on the LED
// and checks button entry. Define SIMON_TIMEOUT_EN to fail on slow input.
module simon_seq_player
  import simon_pkg::*;
#(
  parameter int MAX_LEN        = 16,
  parameter int SHOW_CYCLES    = 8,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic [1:0]                   i_rand_color,
  input  logic                         i_btn_valid,
  input  logic [1:0]                   i_btn_color,
  output logic                         o_led_on,
  output logic [1:0]                   o_led_color,
  output logic                         o_awaiting_input,
  output logic                         o_round_ok,
  output logic                         o_game_over,
  output logic                         o_win,
  output logic [$clog2(MAX_LEN+1)-1:0] o_seq_len
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = clog2_min1(MAX_LEN);
  localparam int TW = clog2_min1(max3(SHOW_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES));

  state_t          r_state, w_nstate;
  logic [LW-1:0]   r_len;
  logic [IW-1:0]   r_idx;
  color_t          r_mem [MAX_LEN];

  logic            w_len_clr, w_len_inc, w_idx_clr, w_idx_inc;
  logic            w_tmr_load, w_tmr_done;
  logic [TW-1:0]   w_tmr_val;
  logic            w_last, w_full, w_match;
  color_t          w_cur;

  simon_timer #(.W(TW)) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_done     (w_tmr_done)
  );

  assign w_cur   = r_mem[r_idx];
  assign w_last  = (LW'(r_idx) == (r_len - LW'(1)));
  assign w_full  = (r_len == LW'(MAX_LEN));
  assign w_match = (i_btn_color == w_cur);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_state <= IDLE;
    else
      r_state <= w_nstate;
  end

  always_comb begin
    w_nstate   = r_state;
    w_len_clr  = 1'b0;
    w_len_inc  = 1'b0;
    w_idx_clr  = 1'b0;
    w_idx_inc  = 1'b0;
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    case (r_state)
      IDLE, FAIL, WIN: begin
        if (i_start) begin
          w_len_clr = 1'b1;
          w_nstate  = ADD;
        end
      end
      ADD: begin
        w_len_inc  = 1'b1;
        w_idx_clr  = 1'b1;
        w_tmr_load = 1'b1;
        w_tmr_val  = TW'(SHOW_CYCLES - 1);
        w_nstate   = SHOW_ON;
      end
      SHOW_ON: begin
        if (w_tmr_done) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = TW'(GAP_CYCLES - 1);
          w_nstate   = SHOW_OFF;
        end
      end
      SHOW_OFF: begin
        if (w_tmr_done) begin
          if (w_last) begin
            w_idx_clr = 1'b1;
            w_nstate  = WAIT_IN;
`ifdef SIMON_TIMEOUT_EN
            w_tmr_load = 1'b1;
            w_tmr_val  = TW'(TIMEOUT_CYCLES - 1);
`endif
          end else begin
            w_idx_inc  = 1'b1;
            w_tmr_load = 1'b1;
            w_tmr_val  = TW'(SHOW_CYCLES - 1);
            w_nstate   = SHOW_ON;
          end
        end
      end
      WAIT_IN: begin
        // a press in the expiry cycle takes priority over the timeout
        if (i_btn_valid) begin
          if (!w_match)
            w_nstate = FAIL;
          else if (!w_last) begin
            w_idx_inc = 1'b1;
`ifdef SIMON_TIMEOUT_EN
            w_tmr_load = 1'b1;
            w_tmr_val  = TW'(TIMEOUT_CYCLES - 1);
`endif
          end else if (w_full)
            w_nstate = WIN;
          else
            w_nstate = ROUND;
        end
`ifdef SIMON_TIMEOUT_EN
        else if (w_tmr_done)
          w_nstate = FAIL;
`endif
      end
      ROUND:   w_nstate = ADD;
      default: w_nstate = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_len <= '0;
      r_idx <= '0;
    end else begin
      if (w_len_clr)
        r_len <= '0;
      else if (w_len_inc)
        r_len <= r_len + LW'(1);
      if (w_idx_clr)
        r_idx <= '0;
      else if (w_idx_inc)
        r_idx <= r_idx + IW'(1);
    end
  end

  // Store is deliberately not reset; entries are only read below r_len.
  always_ff @(posedge i_clk) begin
    if (w_len_inc)
      r_mem[r_len[IW-1:0]] <= i_rand_color;
  end

  assign o_led_on         = (r_state == SHOW_ON);
  assign o_led_color      = o_led_on ? w_cur : 2'b00;
  assign o_awaiting_input = (r_state == WAIT_IN);
  assign o_round_ok       = (r_state == ROUND);
  assign o_game_over      = (r_state == FAIL);
  assign o_win            = (r_state == WIN);
  assign o_seq_len        = r_len;

endmodule
